// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract unit. One operand bit pair per clock goes through a
// single 1-bit full adder with a registered carry; the WIDTH-bit result and
// its flags are assembled LSB first and published on the RUN->DONE edge.
//
// Handshake: start is sampled only while idle (busy=0); an accepted request
// raises busy until the cycle after the one-cycle done pulse. start seen while
// busy is dropped, never queued. sum/cout/ovf/zero are valid from the done
// cycle and hold until the next done.

// 1-bit full adder used as the serial datapath's only arithmetic element.
module serial_add_sub_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   r_sh_q, r_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   r_next;
    logic               last_bit;

    // The adder always sees the current low bits; its outputs only matter in RUN.
    serial_add_sub_fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign r_next   = {fa_sum, r_sh_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state and datapath updates; every register holds unless told otherwise.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        r_sh_d  = r_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    r_sh_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r_sh_d  = r_next;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // On the MSB, carry_q is the carry into the sign bit, so
                    // carry-in xor carry-out is the two's-complement overflow.
                    sum_d   = r_next;
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    zero_d  = (r_next == '0);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            r_sh_q  <= r_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Handshake flags decode straight from the state register; results are registered.
    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
        sum  = sum_q;
        cout = cout_q;
        ovf  = ovf_q;
        zero = zero_q;
    end

endmodule
